bypass_ctrl: RTL and testbench
==============================

# bypass_ctrl

Forwarding and load-use hazard controller for the 5-stage integer pipeline. It tracks register-write tags for the instructions in EX, MEM and WB. Each cycle it produces the six one-hot-per-operand bypass selects that drive the EX-stage operand muxes. It also raises a load-use stall toward IF/ID and inserts a bubble into EX while the stall is active. It sits beside the ID/EX boundary and feeds the EX operand forwarding mux directly.

## Interface
- `CNT_W`, 16, width of the saturating stall counter
- `clk`  in  1  pipeline clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `id_valid`  in  1  ID holds a real instruction
- `id_rs`, `id_rt`  in  5  source register numbers of the ID instruction
- `id_uses_rs`, `id_uses_rt`  in  1  the ID instruction actually reads rs / rt
- `id_dest`  in  5  destination register of the ID instruction
- `id_wr`  in  1  the ID instruction writes `id_dest`
- `id_is_lw`  in  1  the ID instruction is a load
- `flush`  in  1  squash the ID instruction instead of advancing it into EX
- `bypassAfromMEM`, `bypassAfromALUinWB`, `bypassAfromLWinWB`  out  1  operand A select for the EX instruction
- `bypassBfromMEM`, `bypassBfromALUinWB`, `bypassBfromLWinWB`  out  1  operand B select for the EX instruction
- `stall`  out  1  hold PC and IF/ID this cycle
- `stall_cnt`  out  `CNT_W`  number of stall cycles since reset

## Operation
- Per-stage tag fields: `valid`, `rs`, `rt`, `uses_rs`, `uses_rt`, `dest`, `wr`, `is_lw`. EX keeps all fields; MEM and WB need only `valid`, `dest`, `wr`, `is_lw`.
- Every cycle the tags shift: WB takes MEM, and MEM takes EX.
- EX takes the ID fields, or a bubble (`valid`=0) when `flush` or the internal stall condition is true.
- A stage is a producer for register r when `valid & wr & dest==r & r!=0`.
- Operand A forwarding (EX must have `valid & uses_rs`):
  - `bypassAfromMEM` when MEM is a producer for `ex_rs` and `!mem_is_lw`.
  - `bypassAfromALUinWB` when WB is a producer for `ex_rs`, `!wb_is_lw`, and `bypassAfromMEM` is 0.
  - `bypassAfromLWinWB` when WB is a producer for `ex_rs`, `wb_is_lw`, and `bypassAfromMEM` is 0.
- Operand B uses the same rules with `rt` / `uses_rt`.
- At most one select per operand is high. MEM has priority over WB because it is the newer write.
- Register 0 never forwards and never stalls.
- Stall condition: `id_valid & ex_valid & ex_is_lw & ex_wr & ex_dest!=0 & ((id_uses_rs & id_rs==ex_dest) | (id_uses_rt & id_rt==ex_dest))`.
- `stall` = stall condition `& !flush`. Flush wins.
- A load in MEM matching EX is unreachable because the stall prevents it. Assert that it never occurs; no select is raised for it.
- `stall_cnt` increments on every cycle with `stall`=1 and saturates at all-ones.

## Timing
- Bypass selects and `stall` are combinational from the stage tags and ID inputs, valid within the same cycle. No added latency.
- Tag registers update on the rising edge of `clk`.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM, the bubble is in EX, and the dependent instruction (held in ID) re-evaluates to no stall.
- The load reaches WB when the dependent instruction is in EX. The dependent instruction then gets `bypassXfromLWinWB`.
- Reset: all stage `valid`=0, all six selects 0, `stall`=0, `stall_cnt`=0, immediately and asynchronously.
- Reset mid-stall drops `stall` at once. The first instruction after reset sees no forwarding.
- `flush` and stall in the same cycle: a bubble enters EX, `stall`=0, and the counter does not increment.
- Back-to-back producers of the same register in MEM and WB: only the MEM select is high.

## Structure
- Package `bypass_pkg`: `stage_tag_t` struct (the fields above), `REG_ZERO` = 5'd0, and function `produces(tag, r)`.
- One sub-module, `tag_pipe`: three-stage tag shift register with bubble insert and asynchronous reset.
- The forwarding and stall logic stays in `bypass_ctrl`.

## Test plan
- `add r3` then `sub` reading r3 (rs) next cycle -> that cycle `bypassAfromMEM`=1, other A selects 0, `stall`=0.
- `add r3`, `nop`, `or` reading r3 (rt) -> `bypassBfromALUinWB`=1.
- `lw r5`, `add` reading r5 (rs) -> `stall`=1 for 1 cycle and `stall_cnt`=1. Next cycle EX holds a bubble; the cycle after, `bypassAfromLWinWB`=1.
- `add r3` followed by `add r3` (both in pipe), then a reader of r3 -> only `bypassAfromMEM`=1; the WB select stays 0.
- Writer of r0, then a reader of r0; also `lw r0` then a reader of r0 -> no select, no stall.
- Stall condition with `flush`=1 -> `stall`=0, bubble in EX, `stall_cnt` unchanged. Assert `reset` during a stall -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/bypass_pkg.sv
// Shared types for the EX-stage forwarding and load-use stall controller.
// Stage tags, the zero register constant and the producer test.
package bypass_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] dest;
        logic       wr;
        logic       is_lw;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;

    // A stage produces r when it will write a nonzero r.
    function automatic logic produces(input stage_tag_t tag,
                                      input logic [4:0] r);
        return tag.valid & tag.wr & (tag.dest == r) & (r != REG_ZERO);
    endfunction

    // MEM and WB keep only the write-side fields.
    function automatic stage_tag_t write_side(input stage_tag_t tag);
        stage_tag_t t;
        t       = TAG_BUBBLE;
        t.valid = tag.valid;
        t.dest  = tag.dest;
        t.wr    = tag.wr;
        t.is_lw = tag.is_lw;
        return t;
    endfunction

endpackage

// File: rtl/bypass_ctrl_tag_pipe.sv
// Three-stage tag shift register (EX, MEM, WB).
// EX loads the ID tag or a bubble; MEM and WB follow.
module tag_pipe
    import bypass_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  stage_tag_t id_tag_i,
    input  logic       bubble_i,
    output stage_tag_t ex_o,
    output stage_tag_t mem_o,
    output stage_tag_t wb_o
);

    stage_tag_t ex_q,  ex_d;
    stage_tag_t mem_q, mem_d;
    stage_tag_t wb_q,  wb_d;

    // Next-state: shift down, insert bubble into EX on request.
    always_comb begin
        ex_d  = id_tag_i;
        if (bubble_i || !id_tag_i.valid) begin
            ex_d = TAG_BUBBLE;
        end
        mem_d = write_side(ex_q);
        wb_d  = write_side(mem_q);
    end

    // Tag registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= TAG_BUBBLE;
            mem_q <= TAG_BUBBLE;
            wb_q  <= TAG_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/bypass_ctrl.sv
// EX operand forwarding selects and load-use stall generation.
// Also counts stall cycles with a saturating counter.
module bypass_ctrl
    import bypass_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_wr,
    input  logic             id_is_lw,
    input  logic             flush,
    output logic             bypassAfromMEM,
    output logic             bypassAfromALUinWB,
    output logic             bypassAfromLWinWB,
    output logic             bypassBfromMEM,
    output logic             bypassBfromALUinWB,
    output logic             bypassBfromLWinWB,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_tag_t id_tag;
    stage_tag_t ex_tag;
    stage_tag_t mem_tag;
    stage_tag_t wb_tag;

    logic stall_cond;
    logic lw_mem_hazard;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign id_tag = '{
        valid:   id_valid,
        rs:      id_rs,
        rt:      id_rt,
        uses_rs: id_uses_rs,
        uses_rt: id_uses_rt,
        dest:    id_dest,
        wr:      id_wr,
        is_lw:   id_is_lw
    };

    tag_pipe u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .id_tag_i (id_tag),
        .bubble_i (flush | stall_cond),
        .ex_o     (ex_tag),
        .mem_o    (mem_tag),
        .wb_o     (wb_tag)
    );

    // Load in EX whose result the ID instruction reads.
    always_comb begin
        stall_cond = 1'b0;
        if (id_valid && ex_tag.valid && ex_tag.is_lw &&
            ex_tag.wr && ex_tag.dest != REG_ZERO) begin
            stall_cond = (id_uses_rs && id_rs == ex_tag.dest) ||
                         (id_uses_rt && id_rt == ex_tag.dest);
        end
        stall = stall_cond & ~flush;
    end

    // Operand selects; MEM is the newer write so it wins over WB.
    always_comb begin
        logic a_mem, a_wb;
        logic b_mem, b_wb;
        a_mem = 1'b0;
        a_wb  = 1'b0;
        b_mem = 1'b0;
        b_wb  = 1'b0;
        if (ex_tag.valid && ex_tag.uses_rs) begin
            a_mem = produces(mem_tag, ex_tag.rs) & ~mem_tag.is_lw;
            a_wb  = produces(wb_tag, ex_tag.rs) & ~a_mem;
        end
        if (ex_tag.valid && ex_tag.uses_rt) begin
            b_mem = produces(mem_tag, ex_tag.rt) & ~mem_tag.is_lw;
            b_wb  = produces(wb_tag, ex_tag.rt) & ~b_mem;
        end
        bypassAfromMEM     = a_mem;
        bypassAfromALUinWB = a_wb & ~wb_tag.is_lw;
        bypassAfromLWinWB  = a_wb & wb_tag.is_lw;
        bypassBfromMEM     = b_mem;
        bypassBfromALUinWB = b_wb & ~wb_tag.is_lw;
        bypassBfromLWinWB  = b_wb & wb_tag.is_lw;
    end

    // A load in MEM feeding EX means the stall was bypassed.
    always_comb begin
        lw_mem_hazard = 1'b0;
        if (ex_tag.valid && mem_tag.is_lw) begin
            lw_mem_hazard =
                (ex_tag.uses_rs && produces(mem_tag, ex_tag.rs)) ||
                (ex_tag.uses_rt && produces(mem_tag, ex_tag.rt));
        end
    end

    // Catch the unreachable MEM-load forward.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!lw_mem_hazard)
                else $error("load in MEM feeds EX operand");
        end
    end

    // Saturating stall counter next-state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_bypass_ctrl.sv
// Self-checking bench for bypass_ctrl.
// Directed scenarios plus random traffic against a pipeline model.
module tb_bypass_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_dest;
    logic        id_wr;
    logic        id_is_lw;
    logic        flush;
    logic        aM, aAW, aLW;
    logic        bM, bAW, bLW;
    logic        stall;
    logic [15:0] stall_cnt;

    int tests;
    int fails;

    bypass_ctrl #(.CNT_W(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .id_valid           (id_valid),
        .id_rs              (id_rs),
        .id_rt              (id_rt),
        .id_uses_rs         (id_uses_rs),
        .id_uses_rt         (id_uses_rt),
        .id_dest            (id_dest),
        .id_wr              (id_wr),
        .id_is_lw           (id_is_lw),
        .flush              (flush),
        .bypassAfromMEM     (aM),
        .bypassAfromALUinWB (aAW),
        .bypassAfromLWinWB  (aLW),
        .bypassBfromMEM     (bM),
        .bypassBfromALUinWB (bAW),
        .bypassBfromLWinWB  (bLW),
        .stall              (stall),
        .stall_cnt          (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [2:0] a_sel = {aM, aAW, aLW};
    wire [2:0] b_sel = {bM, bAW, bLW};

    typedef struct {
        bit       v;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       urs;
        bit       urt;
        bit [4:0] d;
        bit       wr;
        bit       lw;
    } ins_t;

    // Model: instructions in flight, oldest last.
    ins_t pipe[3];
    ins_t cur;
    bit   cur_flush;
    int   m_cnt;

    function automatic ins_t nop();
        ins_t i;
        i = '{default: 0};
        return i;
    endfunction

    function automatic ins_t alu(bit [4:0] d, bit [4:0] rs, bit [4:0] rt,
                                 bit urs, bit urt, bit lw);
        ins_t i;
        i = '{v: 1, rs: rs, rt: rt, urs: urs, urt: urt,
              d: d, wr: 1, lw: lw};
        return i;
    endfunction

    function automatic ins_t reader(bit [4:0] rs, bit urs,
                                    bit [4:0] rt, bit urt);
        ins_t i;
        i = '{v: 1, rs: rs, rt: rt, urs: urs, urt: urt,
              d: 0, wr: 0, lw: 0};
        return i;
    endfunction

    // Newest older writer of r supplies the value.
    function automatic bit [2:0] exp_fwd(bit [4:0] r, bit use_r);
        ins_t ex, mem, wb;
        ex  = pipe[0];
        mem = pipe[1];
        wb  = pipe[2];
        if (!ex.v || !use_r || r == 0) return 3'b000;
        if (mem.v && mem.wr && mem.d == r) return mem.lw ? 3'b000 : 3'b100;
        if (wb.v && wb.wr && wb.d == r) return wb.lw ? 3'b001 : 3'b010;
        return 3'b000;
    endfunction

    function automatic bit exp_stall();
        ins_t ex;
        bit   dep;
        ex  = pipe[0];
        if (!cur.v || !ex.v || !ex.lw || !ex.wr || ex.d == 0) return 0;
        dep = (cur.urs && cur.rs == ex.d) || (cur.urt && cur.rt == ex.d);
        return dep && !cur_flush;
    endfunction

    function automatic bit held();
        ins_t ex;
        ex = pipe[0];
        if (!cur.v || !ex.v || !ex.lw || !ex.wr || ex.d == 0) return 0;
        return (cur.urs && cur.rs == ex.d) || (cur.urt && cur.rt == ex.d);
    endfunction

    task automatic apply(input ins_t i, input bit f);
        cur        = i;
        cur_flush  = f;
        id_valid   = i.v;
        id_rs      = i.rs;
        id_rt      = i.rt;
        id_uses_rs = i.urs;
        id_uses_rt = i.urt;
        id_dest    = i.d;
        id_wr      = i.wr;
        id_is_lw   = i.lw;
        flush      = f;
        #1;
    endtask

    task automatic tick();
        bit s;
        bit bub;
        s   = exp_stall();
        bub = held() || cur_flush;
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = bub ? nop() : cur;
        if (s && m_cnt < 65535) m_cnt++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) pipe[k] = nop();
        m_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic drain();
        apply(nop(), 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        apply(nop(), 0);
        do_reset();
        tests++;
        if ({a_sel, b_sel, stall} !== 7'b0 || stall_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset: sel=%b%b stall=%b cnt=%0d want 0",
                     a_sel, b_sel, stall, stall_cnt);
        end
    endtask

    task automatic test_mem_fwd();
        apply(alu(3, 1, 2, 1, 1, 0), 0);
        tick();
        apply(reader(3, 1, 4, 1), 0);
        tick();
        apply(nop(), 0);
        tests++;
        if (a_sel !== 3'b100 || stall !== 1'b0) begin
            fails++;
            $display("FAIL mem_fwd: a=%b stall=%b want 100/0", a_sel, stall);
        end
        drain();
    endtask

    task automatic test_wb_fwd();
        apply(alu(3, 1, 2, 1, 1, 0), 0);
        tick();
        apply(nop(), 0);
        tick();
        apply(reader(6, 0, 3, 1), 0);
        tick();
        apply(nop(), 0);
        tests++;
        if (b_sel !== 3'b010 || a_sel !== 3'b000) begin
            fails++;
            $display("FAIL wb_fwd: a=%b b=%b want 000/010", a_sel, b_sel);
        end
        drain();
    endtask

    task automatic test_load_use();
        int c0;
        c0 = int'(stall_cnt);
        apply(alu(5, 1, 0, 1, 0, 1), 0);
        tick();
        apply(reader(5, 1, 0, 0), 0);
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL lu_stall: stall=%b want 1", stall);
        end
        tick();
        tests++;
        if (stall !== 1'b0 || int'(stall_cnt) !== c0 + 1 ||
            a_sel !== 3'b000) begin
            fails++;
            $display("FAIL lu_bubble: stall=%b cnt=%0d a=%b want 0/%0d/000",
                     stall, stall_cnt, a_sel, c0 + 1);
        end
        tick();
        apply(nop(), 0);
        tests++;
        if (a_sel !== 3'b001 || int'(stall_cnt) !== c0 + 1) begin
            fails++;
            $display("FAIL lu_fwd: a=%b cnt=%0d want 001/%0d",
                     a_sel, stall_cnt, c0 + 1);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        apply(alu(3, 1, 2, 1, 1, 0), 0);
        tick();
        apply(alu(3, 4, 5, 1, 1, 0), 0);
        tick();
        apply(reader(3, 1, 0, 0), 0);
        tick();
        apply(nop(), 0);
        tests++;
        if (a_sel !== 3'b100) begin
            fails++;
            $display("FAIL back_to_back: a=%b want 100", a_sel);
        end
        drain();
    endtask

    task automatic test_r0();
        apply(alu(0, 1, 2, 1, 1, 0), 0);
        tick();
        apply(reader(0, 1, 0, 1), 0);
        tick();
        apply(nop(), 0);
        tests++;
        if ({a_sel, b_sel} !== 6'b0) begin
            fails++;
            $display("FAIL r0_alu: a=%b b=%b want 0", a_sel, b_sel);
        end
        drain();
        apply(alu(0, 1, 0, 1, 0, 1), 0);
        tick();
        apply(reader(0, 1, 0, 1), 0);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL r0_lw: stall=%b want 0", stall);
        end
        drain();
    endtask

    task automatic test_flush_stall();
        int c0;
        c0 = int'(stall_cnt);
        apply(alu(7, 1, 0, 1, 0, 1), 0);
        tick();
        apply(reader(0, 0, 7, 1), 1);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_stall: stall=%b want 0", stall);
        end
        tick();
        apply(nop(), 0);
        tick();
        tests++;
        if (int'(stall_cnt) !== c0 || b_sel !== 3'b000) begin
            fails++;
            $display("FAIL flush_cnt: cnt=%0d b=%b want %0d/000",
                     stall_cnt, b_sel, c0);
        end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        apply(alu(9, 1, 0, 1, 0, 1), 0);
        tick();
        apply(reader(9, 1, 0, 0), 0);
        reset = 1'b1;
        #1;
        tests++;
        if ({a_sel, b_sel, stall} !== 7'b0 || stall_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_stall: sel=%b%b stall=%b cnt=%0d want 0",
                     a_sel, b_sel, stall, stall_cnt);
        end
        do_reset();
        apply(reader(9, 1, 9, 1), 0);
        tick();
        apply(nop(), 0);
        tests++;
        if ({a_sel, b_sel} !== 6'b0) begin
            fails++;
            $display("FAIL post_reset: a=%b b=%b want 0", a_sel, b_sel);
        end
    endtask

    task automatic test_random();
        ins_t i;
        int   bad;
        bad = 0;
        i   = nop();
        for (int n = 0; n < 600; n++) begin
            if (!(held() && !cur_flush) || n == 0) begin
                i.v   = ($urandom_range(0, 9) != 0);
                i.rs  = 5'($urandom_range(0, 3));
                i.rt  = 5'($urandom_range(0, 3));
                i.urs = $urandom_range(0, 1) == 1;
                i.urt = $urandom_range(0, 1) == 1;
                i.d   = 5'($urandom_range(0, 3));
                i.wr  = $urandom_range(0, 3) != 0;
                i.lw  = i.wr && ($urandom_range(0, 2) == 0);
            end
            apply(i, $urandom_range(0, 9) == 0);
            tests++;
            if (a_sel !== exp_fwd(pipe[0].rs, pipe[0].urs) ||
                b_sel !== exp_fwd(pipe[0].rt, pipe[0].urt) ||
                stall !== exp_stall() || int'(stall_cnt) !== m_cnt) begin
                fails++;
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d]: a=%b b=%b s=%b c=%0d want %b %b %b %0d",
                             n, a_sel, b_sel, stall, stall_cnt,
                             exp_fwd(pipe[0].rs, pipe[0].urs),
                             exp_fwd(pipe[0].rt, pipe[0].urt),
                             exp_stall(), m_cnt);
            end
            tick();
        end
        drain();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) pipe[k] = nop();
        m_cnt = 0;
        @(negedge clk);
        test_reset();
        test_mem_fwd();
        test_wb_fwd();
        test_load_use();
        test_back_to_back();
        test_r0();
        test_flush_stall();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
